// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button/tick inputs and datapath command outputs of stopwatch_ctrl
interface stopwatch_ctrl_if;
   logic       tick_100hz;
   logic       start_p;
   logic       stop_p;
   logic       clear_p;
   logic       set_min_p;
   logic       set_hour_p;
   logic       countdown_mode;
   logic       zero_flag;
   logic       count_en;
   logic       count_dir;
   logic       clear_o;
   logic       inc_min;
   logic       inc_hour;
   logic [2:0] state;
   logic       alarm;
   logic       blink;

   modport master (
      output tick_100hz, start_p, stop_p, clear_p, set_min_p, set_hour_p,
      output countdown_mode, zero_flag,
      input  count_en, count_dir, clear_o, inc_min, inc_hour, state, alarm, blink
   );

   modport slave (
      input  tick_100hz, start_p, stop_p, clear_p, set_min_p, set_hour_p,
      input  countdown_mode, zero_flag,
      output count_en, count_dir, clear_o, inc_min, inc_hour, state, alarm, blink
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM: run/pause/alarm sequencing, registered datapath strobes
module stopwatch_ctrl #(
   parameter int ALARM_TICKS = 300,
   parameter int BLINK_TICKS = 25
) (
   input  logic            clk,
   input  logic            rst_n,
   stopwatch_ctrl_if.slave sw
);
   localparam int              BW        = $clog2(BLINK_TICKS + 1);
   localparam logic [8:0]      ALARM_LIM = 9'(ALARM_TICKS);
   localparam logic [BW-1:0]   BLINK_LIM = BW'(BLINK_TICKS);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_ALARM = 3'd3
   } state_t;

   state_t        state_q, state_n;
   logic          count_en_q, count_en_n;
   logic          dir_q, dir_n;
   logic          clear_q, clear_n;
   logic          imin_q, imin_n;
   logic          ihour_q, ihour_n;
   logic          alarm_q, alarm_n;
   logic          blink_q, blink_n;
   logic [8:0]    acnt_q, acnt_n;
   logic [BW-1:0] bcnt_q, bcnt_n;
   logic          do_stop, do_start, do_hour, do_min, any_btn;

   // Priority-resolved pulses; clear is handled ahead of everything else below.
   always_comb begin
      do_stop  = sw.stop_p & ~sw.clear_p;
      do_start = sw.start_p & ~sw.stop_p & ~sw.clear_p;
      do_hour  = sw.set_hour_p & ~sw.start_p & ~sw.stop_p & ~sw.clear_p;
      do_min   = sw.set_min_p & ~sw.set_hour_p & ~sw.start_p & ~sw.stop_p & ~sw.clear_p;
      any_btn  = sw.start_p | sw.stop_p | sw.set_min_p | sw.set_hour_p;
   end

   always_comb begin
      state_n    = state_q;
      count_en_n = 1'b0;
      dir_n      = dir_q;
      clear_n    = 1'b0;
      imin_n     = 1'b0;
      ihour_n    = 1'b0;
      acnt_n     = acnt_q;
      bcnt_n     = bcnt_q;
      blink_n    = blink_q;
      if (sw.clear_p) begin
         state_n = ST_IDLE;
         clear_n = 1'b1;
         acnt_n  = '0;
         bcnt_n  = '0;
         blink_n = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSE: begin
               if (do_start) begin
                  // A countdown from zero would alarm immediately, so refuse it.
                  if (!(sw.countdown_mode && sw.zero_flag)) begin
                     state_n = ST_RUN;
                     dir_n   = sw.countdown_mode;
                  end
               end else if (do_hour) begin
                  ihour_n = 1'b1;
               end else if (do_min) begin
                  imin_n = 1'b1;
               end
            end
            ST_RUN: begin
               if (do_stop || (sw.countdown_mode != dir_q)) begin
                  state_n = ST_PAUSE;
               end else if (sw.tick_100hz) begin
                  if (dir_q && sw.zero_flag) begin
                     state_n = ST_ALARM;
                     acnt_n  = '0;
                     bcnt_n  = '0;
                     blink_n = 1'b1;
                  end else begin
                     count_en_n = 1'b1;
                  end
               end
            end
            ST_ALARM: begin
               if (any_btn || (sw.tick_100hz && (acnt_q + 9'd1 == ALARM_LIM))) begin
                  state_n = ST_IDLE;
                  acnt_n  = '0;
                  bcnt_n  = '0;
                  blink_n = 1'b0;
               end else if (sw.tick_100hz) begin
                  acnt_n = acnt_q + 9'd1;
                  if (bcnt_q + 1'b1 == BLINK_LIM) begin
                     bcnt_n  = '0;
                     blink_n = ~blink_q;
                  end else begin
                     bcnt_n = bcnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_n = ST_IDLE;
               acnt_n  = '0;
               bcnt_n  = '0;
               blink_n = 1'b0;
            end
         endcase
      end
      alarm_n = (state_n == ST_ALARM);
      blink_n = blink_n & alarm_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_en_q <= 1'b0;
         dir_q      <= 1'b0;
         clear_q    <= 1'b0;
         imin_q     <= 1'b0;
         ihour_q    <= 1'b0;
         alarm_q    <= 1'b0;
         blink_q    <= 1'b0;
         acnt_q     <= '0;
         bcnt_q     <= '0;
      end else begin
         state_q    <= state_n;
         count_en_q <= count_en_n;
         dir_q      <= dir_n;
         clear_q    <= clear_n;
         imin_q     <= imin_n;
         ihour_q    <= ihour_n;
         alarm_q    <= alarm_n;
         blink_q    <= blink_n;
         acnt_q     <= acnt_n;
         bcnt_q     <= bcnt_n;
      end
   end

   assign sw.state     = state_q;
   assign sw.count_en  = count_en_q;
   assign sw.count_dir = dir_q;
   assign sw.clear_o   = clear_q;
   assign sw.inc_min   = imin_q;
   assign sw.inc_hour  = ihour_q;
   assign sw.alarm     = alarm_q;
   assign sw.blink     = blink_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed vector bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   // input bit positions: {tick, start, stop, clear, set_min, set_hour, mode, zero}
   localparam logic [7:0] TK = 8'h80, ST = 8'h40, SP = 8'h20, CL = 8'h10;
   localparam logic [7:0] SM = 8'h08, SH = 8'h04, MD = 8'h02, ZF = 8'h01, NO = 8'h00;

   typedef struct {
      logic [7:0] in;
      logic [9:0] exp;
   } vec_t;

   vec_t tbl[$];

   stopwatch_ctrl_if sif ();

   stopwatch_ctrl #(.ALARM_TICKS(300), .BLINK_TICKS(25)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sif.slave)
   );

   always #5 clk = ~clk;

   // {state, count_en, count_dir, clear_o, inc_min, inc_hour, alarm, blink}
   function automatic logic [9:0] e(input logic [2:0] st, input logic cen, input logic dir,
                                    input logic clro, input logic imin, input logic ihour,
                                    input logic alm, input logic blk);
      return {st, cen, dir, clro, imin, ihour, alm, blk};
   endfunction

   function automatic logic [9:0] outs();
      return {sif.state, sif.count_en, sif.count_dir, sif.clear_o,
              sif.inc_min, sif.inc_hour, sif.alarm, sif.blink};
   endfunction

   task automatic drive(input logic [7:0] v);
      {sif.tick_100hz, sif.start_p, sif.stop_p, sif.clear_p,
       sif.set_min_p, sif.set_hour_p, sif.countdown_mode, sif.zero_flag} = v;
   endtask

   task automatic step(input logic [7:0] v);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n, input logic [7:0] lvl);
      for (int i = 0; i < n; i++) begin
         step(TK | lvl);
         step(lvl);
      end
   endtask

   task automatic check(input string name, input logic [9:0] exp);
      logic [9:0] act;
      act = outs();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got st/cen/dir/clr/imin/ihour/alm/blk=%b required %b", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] i, input logic [9:0] x);
      vec_t v;
      v.in  = i;
      v.exp = x;
      tbl.push_back(v);
   endtask

   initial begin
      drive(NO);
      @(posedge clk);
      #1;
      check("reset", e(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      add(NO,              e(0, 0, 0, 0, 0, 0, 0, 0));
      add(ST,              e(1, 0, 0, 0, 0, 0, 0, 0));
      add(TK,              e(1, 1, 0, 0, 0, 0, 0, 0));
      add(NO,              e(1, 0, 0, 0, 0, 0, 0, 0));
      add(TK,              e(1, 1, 0, 0, 0, 0, 0, 0));
      add(TK,              e(1, 1, 0, 0, 0, 0, 0, 0));
      add(TK | SH,         e(1, 1, 0, 0, 0, 0, 0, 0));
      add(TK,              e(1, 1, 0, 0, 0, 0, 0, 0));
      add(TK | SP,         e(2, 0, 0, 0, 0, 0, 0, 0));
      add(TK,              e(2, 0, 0, 0, 0, 0, 0, 0));
      add(SM,              e(2, 0, 0, 0, 1, 0, 0, 0));
      add(SH,              e(2, 0, 0, 0, 0, 1, 0, 0));
      add(ST | SM,         e(1, 0, 0, 0, 0, 0, 0, 0));
      add(TK | MD,         e(2, 0, 0, 0, 0, 0, 0, 0));
      add(ST | MD,         e(1, 0, 1, 0, 0, 0, 0, 0));
      add(TK | MD,         e(1, 1, 1, 0, 0, 0, 0, 0));
      add(TK | CL | SP | ST | MD, e(0, 0, 1, 1, 0, 0, 0, 0));
      add(MD,              e(0, 0, 1, 0, 0, 0, 0, 0));
      add(ST | MD | ZF,    e(0, 0, 1, 0, 0, 0, 0, 0));
      add(SM | MD,         e(0, 0, 1, 0, 1, 0, 0, 0));
      add(ST | MD,         e(1, 0, 1, 0, 0, 0, 0, 0));
      add(TK | MD,         e(1, 1, 1, 0, 0, 0, 0, 0));
      add(TK | MD,         e(1, 1, 1, 0, 0, 0, 0, 0));
      add(TK | MD,         e(1, 1, 1, 0, 0, 0, 0, 0));
      add(TK | MD | ZF,    e(3, 0, 1, 0, 0, 0, 1, 1));
      add(MD | ZF,         e(3, 0, 1, 0, 0, 0, 1, 1));

      foreach (tbl[i]) begin
         step(tbl[i].in);
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // alarm blink cadence and timeout
      ticks(24, MD | ZF);
      check("blink_t24", e(3, 0, 1, 0, 0, 0, 1, 1));
      ticks(1, MD | ZF);
      check("blink_t25", e(3, 0, 1, 0, 0, 0, 1, 0));
      ticks(25, MD | ZF);
      check("blink_t50", e(3, 0, 1, 0, 0, 0, 1, 1));
      ticks(249, MD | ZF);
      check("alarm_t299", e(3, 0, 1, 0, 0, 0, 1, 0));
      ticks(1, MD | ZF);
      check("alarm_timeout", e(0, 0, 1, 0, 0, 0, 0, 0));

      // dismissing pulses take no other action
      step(ST | MD);
      step(TK | MD | ZF);
      check("alarm_again", e(3, 0, 1, 0, 0, 0, 1, 1));
      step(SM | MD | ZF);
      check("dismiss_min", e(0, 0, 1, 0, 0, 0, 0, 0));
      step(ST | MD);
      step(TK | MD | ZF);
      step(ST | MD);
      check("dismiss_start", e(0, 0, 1, 0, 0, 0, 0, 0));
      step(ST | MD);
      step(TK | MD | ZF);
      step(CL | MD);
      check("clear_alarm", e(0, 0, 1, 1, 0, 0, 0, 0));

      // asynchronous reset in the middle of an alarm
      step(ST | MD);
      step(TK | MD | ZF);
      ticks(3, MD | ZF);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", e(0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(MD | ZF);
      check("post_reset_idle", e(0, 0, 0, 0, 0, 0, 0, 0));
      step(ST | MD);
      check("restart_down", e(1, 0, 1, 0, 0, 0, 0, 0));
      step(TK | MD | ZF);
      ticks(24, MD | ZF);
      check("fresh_blink_t24", e(3, 0, 1, 0, 0, 0, 1, 1));
      ticks(1, MD | ZF);
      check("fresh_blink_t25", e(3, 0, 1, 0, 0, 0, 1, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter ALARM_TICKS, default 300, alarm duration in tick_100hz periods (3 s).
REQ-002 SHALL have parameter BLINK_TICKS, default 25, blink half-period in tick_100hz periods.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz; single clock domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tick_100hz  input  1  single-cycle enable pulse at 100 Hz, synchronous to clk.
REQ-006 SHALL have ports start_p, stop_p, clear_p, set_min_p, set_hour_p  input  1 each  debounced single-cycle button pulses.
REQ-007 SHALL have port countdown_mode  input  1  debounced level; 1 = count down, 0 = count up.
REQ-008 SHALL have port zero_flag  input  1  datapath reports hh:mm:ss.xx all zero.
REQ-009 SHALL have port count_en  output  1  one-cycle advance strobe to the counter datapath.
REQ-010 SHALL have port count_dir  output  1  0 = up, 1 = down; valid whenever count_en is 1.
REQ-011 SHALL have ports clear_o, inc_min, inc_hour  output  1 each  one-cycle datapath commands.
REQ-012 SHALL have port state  output  3  current state encoding: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
REQ-013 SHALL have ports alarm, blink  output  1 each  alarm active; display blink phase.

Function
REQ-014 SHALL register all outputs; response to an input pulse appears exactly 1 clk later.
REQ-015 SHALL resolve same-cycle pulses by priority clear_p > stop_p > start_p > set_hour_p > set_min_p; lower-priority pulses that cycle are dropped.
REQ-016 SHALL, on clear_p in any state, pulse clear_o, go to IDLE, zero alarm/blink counters.
REQ-017 IDLE: start_p -> RUN, latching count_dir = countdown_mode; start_p ignored if countdown_mode=1 and zero_flag=1.
REQ-018 IDLE and PAUSE: set_min_p pulses inc_min, set_hour_p pulses inc_hour, state unchanged; these pulses SHALL be ignored in RUN and ALARM.
REQ-019 RUN: count_en SHALL equal tick_100hz delayed 1 clk; count_en SHALL be 0 in all other states.
REQ-020 RUN: stop_p -> PAUSE; first count_en suppressed from that cycle on.
REQ-021 RUN: countdown_mode differing from latched count_dir -> PAUSE (no count_en issued that cycle).
REQ-022 RUN with count_dir=1: tick_100hz while zero_flag=1 -> ALARM, no count_en issued (no underflow past 00:00:00.00).
REQ-023 RUN with count_dir=0: wrap of datapath is datapath's concern; controller keeps counting.
REQ-024 PAUSE: start_p -> RUN, re-latching count_dir = countdown_mode, same zero_flag guard as REQ-017.
REQ-025 ALARM: alarm=1; 9-bit tick counter increments per tick_100hz; blink toggles every BLINK_TICKS ticks, starting at 1 on entry.
REQ-026 ALARM: counter reaching ALARM_TICKS or any of start_p/stop_p/set_min_p/set_hour_p -> IDLE, alarm=0, blink=0; the dismissing pulse SHALL NOT cause any other action.
REQ-027 blink SHALL be 0 outside ALARM.
REQ-028 Unused state encodings SHALL recover to IDLE on the next clk.

Reset
REQ-029 While rst_n=0: state=IDLE, count_en=0, count_dir=0, clear_o=0, inc_min=0, inc_hour=0, alarm=0, blink=0, internal counters 0.
REQ-030 Reset assertion mid-RUN or mid-ALARM SHALL take effect immediately, without waiting for clk; first state change after deassertion requires a clk edge with a valid pulse.

Verification
REQ-031 Count up: countdown_mode=0, start_p, 5 ticks -> state=1, 5 count_en pulses each 1 clk after tick, count_dir=0.
REQ-032 Countdown expiry: countdown_mode=1, zero_flag=0, start_p, 3 ticks, raise zero_flag, 1 tick -> state=3, alarm=1, blink=1, no 4th count_en; after 300 ticks state=0, alarm=0.
REQ-033 Priority: clear_p+stop_p+start_p same cycle in RUN -> clear_o=1 for 1 clk, state=0, no count_en.
REQ-034 Set gating: set_min_p in IDLE -> inc_min 1 clk; set_hour_p in RUN -> no inc_hour, state stays 1.
REQ-035 Mode flip: RUN up, toggle countdown_mode -> state=2 next clk; start_p -> state=1, count_dir=1.
REQ-036 Async reset: drop rst_n mid-ALARM with no clk edge -> all outputs at REQ-029 values immediately; blink toggle observed at tick 25 in a fresh ALARM.
